// File: rtl/bga_continuity_scanner.sv
// BGA solder-joint continuity scanner: walks a one/zero over looped-back pin
// pairs, compares the synchronised echo and accumulates fault statistics.
module bga_continuity_scanner #(
  parameter int unsigned N_PAIR  = 86,
  parameter int unsigned IDX_W   = 7,
  parameter int unsigned DWELL_W = 5,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic               continuous,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_PAIR-1:0]  pins_o,
  input  logic [N_PAIR-1:0]  pins_i,
  output logic               busy,
  output logic               done,
  output logic               fail_sticky,
  output logic [N_PAIR-1:0]  fail_map,
  output logic [CNT_W-1:0]   fail_count,
  output logic [IDX_W-1:0]   first_fail_idx,
  output logic               first_fail_valid,
  output logic [CNT_W-1:0]   pass_count
);

  // Two synchroniser stages plus one settle cycle need a dwell of at least 3.
  localparam int unsigned MIN_DWELL = 3;
  localparam logic [IDX_W-1:0]  LAST_STEP = IDX_W'(N_PAIR - 1);
  localparam logic [N_PAIR-1:0] ONE_BIT   = N_PAIR'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state;
  logic               mode_q;
  logic               cont_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [IDX_W-1:0]   step;
  logic [N_PAIR-1:0]  sync_q1;
  logic [N_PAIR-1:0]  sync_q2;
  logic [DWELL_W-1:0] eff_dwell_c;
  logic [N_PAIR-1:0]  mis_c;

  // Drive pattern for a given step: one-hot, or its complement in walking-zero mode.
  function automatic logic [N_PAIR-1:0] pattern(input logic m, input logic [IDX_W-1:0] s);
    logic [N_PAIR-1:0] oh;
    oh = ONE_BIT << s;
    return m ? ~oh : oh;
  endfunction

  // Dwell clamp and echo mismatch against the currently driven pattern.
  always_comb begin
    eff_dwell_c = (dwell < DWELL_W'(MIN_DWELL)) ? DWELL_W'(MIN_DWELL) : dwell;
    mis_c       = pins_o ^ sync_q2;
  end

  // Two-flop synchroniser for the asynchronous loopback inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= pins_i;
      sync_q2 <= sync_q1;
    end
  end

  // Scan FSM with registered pattern, status and result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      mode_q           <= 1'b0;
      cont_q           <= 1'b0;
      dwell_q          <= '0;
      dwell_cnt        <= '0;
      step             <= '0;
      pins_o           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      fail_sticky      <= 1'b0;
      fail_map         <= '0;
      fail_count       <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
      pass_count       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start && !abort) begin
            state            <= S_DRIVE;
            busy             <= 1'b1;
            done             <= 1'b0;
            mode_q           <= mode;
            cont_q           <= continuous;
            dwell_q          <= eff_dwell_c;
            dwell_cnt        <= '0;
            step             <= '0;
            pins_o           <= pattern(mode, '0);
            fail_sticky      <= 1'b0;
            fail_map         <= '0;
            fail_count       <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
            pass_count       <= '0;
          end
        end
        S_DRIVE: begin
          if (abort) begin
            // Partial pass discarded; results stay visible.
            state     <= S_IDLE;
            busy      <= 1'b0;
            pins_o    <= '0;
            dwell_cnt <= '0;
          end else if (dwell_cnt == dwell_q) begin
            fail_map  <= fail_map | mis_c;
            dwell_cnt <= '0;
            if (mis_c != '0) begin
              fail_sticky <= 1'b1;
              if (fail_count != '1) begin
                fail_count <= fail_count + CNT_W'(1);
              end
              if (!first_fail_valid) begin
                first_fail_idx   <= step;
                first_fail_valid <= 1'b1;
              end
            end
            if (step == LAST_STEP) begin
              pass_count <= pass_count + CNT_W'(1);
              if (cont_q) begin
                step   <= '0;
                pins_o <= pattern(mode_q, '0);
              end else begin
                state  <= S_DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
                pins_o <= '0;
              end
            end else begin
              step   <= step + IDX_W'(1);
              pins_o <= pattern(mode_q, step + IDX_W'(1));
            end
          end else begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          pins_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/bga_continuity_scanner.md
Name: bga_continuity_scanner

Overview:
- Parametrised successor to the single-pattern BGA solder-joint tester.
- Drives a walking-one or walking-zero pattern over N_PAIR looped-back output/input pin pairs and compares each step against the looped-back inputs.
- Records a per-pin fault map, saturating fault count, first failing step index and a completed-pass count, with one-shot or continuous operation.
- Sits between the pin bank and the status LED/debug readout logic of the BGA soldering test board.

Parameters:
- N_PAIR, 86, number of output/input pin pairs under test.
- IDX_W, 7, width of step index; must satisfy 2^IDX_W >= N_PAIR.
- DWELL_W, 5, width of per-step dwell setting.
- CNT_W, 8, width of fault and pass counters.

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  level-sampled request; begins a scan from IDLE or DONE.
- abort  in  1  stops a scan, returns to IDLE and keeps results.
- mode  in  1  0 = walking-one, 1 = walking-zero; latched at start.
- continuous  in  1  1 = wrap after the last step; latched at start.
- dwell  in  DWELL_W  cycles per step minus 1; latched at start; effective value max(dwell,3).
- pins_o  out  N_PAIR  registered drive pattern.
- pins_i  in  N_PAIR  asynchronous loopback inputs.
- busy  out  1  high in DRIVE.
- done  out  1  high in DONE.
- fail_sticky  out  1  set by any mismatch; cleared only by start or reset.
- fail_map  out  N_PAIR  OR-accumulated mismatch bits.
- fail_count  out  CNT_W  failing steps, saturating at all-ones.
- first_fail_idx  out  IDX_W  step index of first failing step.
- first_fail_valid  out  1  first_fail_idx holds a valid value.
- pass_count  out  CNT_W  completed full passes, wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, reset_n low):
  - FSM goes to IDLE; pins_o = 0.
  - busy, done, fail_sticky, first_fail_valid = 0.
  - fail_map, fail_count, first_fail_idx, pass_count = 0.
  - Step and dwell counters = 0; synchroniser flops = 0.
- FSM states: IDLE, DRIVE, DONE.
  - IDLE/DONE with start=1 and abort=0 -> DRIVE on the next edge. This edge also latches mode, continuous and effective dwell, sets step=0 and dwell_cnt=0, and clears all result outputs.
  - DRIVE: pins_o = one-hot(step) for mode 0, ~one-hot(step) for mode 1. pins_o updates on the same edge that step changes.
  - In DRIVE, dwell_cnt increments every cycle.
- Sample and step advance:
  - pins_i passes through a 2-flop synchroniser.
  - Comparison happens when dwell_cnt == effective dwell: mis = pins_o ^ sync_in.
  - On that cycle: fail_map |= mis; if mis != 0, fail_sticky <= 1 and fail_count increments with saturation.
  - If mis != 0 and first_fail_valid == 0: first_fail_idx <= step and first_fail_valid <= 1.
  - Then dwell_cnt <= 0 and step <= step+1.
  - At step == N_PAIR-1 the pass completes: pass_count increments. Then continuous=1 -> step <= 0, stay in DRIVE; continuous=0 -> DONE.
- DONE: pins_o = 0; results held.
- IDLE: pins_o = 0.
- abort: from DRIVE goes to IDLE on the next edge.
  - abort takes priority over a same-cycle sample; that sample is discarded.
  - abort takes priority over start.
  - The partial pass is not counted; results are retained.
- start while in DRIVE is ignored.
- Changes to mode, continuous or dwell during DRIVE have no effect until the next start.
- Scan time per pass = N_PAIR*(effective dwell+1) cycles; total latency from start to done = that plus 1 cycle.
- Stuck, shorted or open pins show in fail_map at the driven pin and/or at the pins that echoed it.

Test Plan:
- N_PAIR=8, dwell=3, mode=0, perfect loopback (pins_i=pins_o), start pulse -> pins_o walks 0x01..0x80 with 4 cycles per step; done rises 33 cycles after start; fail_sticky=0, fail_map=0x00, pass_count=1.
- pins_i bit 5 tied 0, mode=0 -> step 5 fails; fail_map=0x20, fail_count=1, first_fail_idx=5, first_fail_valid=1.
- Bits 2 and 3 shorted (pins_i[2]=pins_i[3]=pins_o[2]|pins_o[3]), mode=1 -> steps 2 and 3 fail; fail_map=0x0C, fail_count=2, first_fail_idx=2.
- continuous=1, perfect loopback, 3 passes then abort mid-step -> FSM in IDLE next cycle, pins_o=0, pass_count=3, busy=0, done=0.
- dwell=0 -> effective dwell 3, identical timing to the first scenario.
- continuous=1 with pins_i all 0, run 300 steps -> fail_count saturates at 0xFF; first_fail_idx=0.
- reset_n asserted mid-scan, then released -> all outputs 0; a new start gives a clean result.
